stall_pipeline: RTL and testbench
=================================

// Module: stall_pipeline
// PURPOSE
//   Backpressure-capable counterpart to the team's free-running register pipeline.
//   - Moves WIDTH-bit words through STAGES register stages using a valid/ready handshake.
//   - The downstream consumer can stall the pipe; data is never dropped or duplicated.
//   - Sits between any producer/consumer pair that must honour out_ready.
// PARAMETERS
//   WIDTH   100  data word width in bits
//   STAGES  3    number of register stages (>=1)
// PORTS
//   clk        in   1      single clock; all logic on posedge clk
//   rst_n      in   1      synchronous reset, active-low
//   flush      in   1      synchronous clear of all in-flight words
//   in_valid   in   1      upstream word present
//   in_ready   out  1      pipe accepts a word this cycle
//   in_data    in   WIDTH  upstream word
//   out_valid  out  1      word present at output
//   out_ready  in   1      downstream accepts a word this cycle
//   out_data   out  WIDTH  output word (last stage register)
// BEHAVIOUR
//   - Interface: one clock (clk); reset is synchronous and active-low (rst_n).
//   - Handshake: a transfer occurs on a posedge where valid & ready are both 1.
//     - Producer holds in_data and in_valid stable until in_ready; pipe does likewise on output.
//   - Stage k holds v[k] and d[k]; k=STAGES-1 drives out_valid and out_data.
//   - Stage ready is combinational: rdy[k] = ~v[k] | rdy[k+1]; rdy[STAGES] = out_ready.
//     - This gives bubble collapsing: an empty stage accepts even while downstream stalls.
//   - Per stage on posedge:
//     - If rdy[k], then v[k] <= v[k-1] and d[k] <= d[k-1] (stage 0 takes in_valid and in_data).
//     - Otherwise the stage holds.
//     - d[k] loads only when the incoming valid is 1, so bubbles keep old data.
//   - Latency: a word accepted at edge t is presented at out_valid after edge t+STAGES-1.
//     - This holds when there are no stalls. Full throughput is 1 word per cycle.
//   - Capacity: STAGES words.
//     - With all stages full and out_ready=0: in_ready=0 and the pipe holds.
//     - With all stages full and out_ready=1: in_ready=1, simultaneous accept and emit, count unchanged.
//   - Ordering: strict FIFO order; no reordering, loss or duplication under any stall pattern.
//   - Reset (rst_n=0 at posedge): all v[k]=0, all d[k]=0.
//     - Outputs after reset: out_valid=0, out_data=0, in_ready=1 (0 while rst_n=0 if skid enabled).
//     - Reset mid-stream discards every in-flight word.
//   - flush=1 at posedge: all v[k] <= 0, d[k] unchanged.
//     - Any input handshake in that same cycle is discarded.
//     - rst_n has priority over flush.
//   - out_data is undefined to the consumer while out_valid=0 (in practice it holds its last value).
// CONFIGURATION
//   STALL_PIPELINE_SKID_EN defined:
//   - in_ready is a flop: in_ready = ~skid_v, with no combinational path from out_ready.
//   - A one-entry skid register sits ahead of stage 0.
//     - A word accepted while rdy[0]=0 parks in skid.
//     - skid drains into stage 0 before any new input; skid has priority.
//   - Latency with no stalls is unchanged (skid is bypassed when empty).
//   - Capacity is STAGES+1.
//   - Reset and flush also clear skid_v.
//   STALL_PIPELINE_SKID_EN undefined:
//   - No skid register. in_ready = rdy[0] (combinational from out_ready). Capacity is STAGES.
// TESTING
//   - Reset:
//     - Stimulus: rst_n=0 for 2 cycles with in_valid=1, in_data=100'h5.
//     - Required: out_valid=0, out_data=0; no word emerges after release until new input.
//   - Streaming:
//     - Stimulus: out_ready=1, push 1,2,3,4 back-to-back.
//     - Required: out_valid after edge 3 for the first word (STAGES=3); 1,2,3,4 on consecutive cycles.
//   - Full stall:
//     - Stimulus: out_ready=0, push 10,11,12,13.
//     - Required: 3 accepted (4 with skid), then in_ready=0.
//     - Release out_ready=1: 10,11,12(,13) in order, none lost.
//   - Bubble collapse:
//     - Stimulus: push A, idle 2 cycles, push B, hold out_ready=0.
//     - Required: B still accepted; A and B adjacent at the output after release.
//   - Full-pipe pass-through:
//     - Stimulus: pipe full, out_ready=1 and in_valid=1 for 5 cycles.
//     - Required: 5 in, 5 out, occupancy constant.
//   - Flush:
//     - Stimulus: pipe holds 7,8,9; flush=1 together with in_valid=1, data 20.
//     - Required: out_valid=0 next cycle; 20 is never emitted.

Source files
------------

// File: rtl/stall_pipeline.sv
// stall_pipeline: valid/ready register pipeline with backpressure and bubble collapsing.
// STAGES register stages of WIDTH bits; out_valid/out_data come straight from the last stage.
// Optional feature macro: STALL_PIPELINE_SKID_EN (registered in_ready plus a one-entry skid buffer).
module stall_pipeline #(
    parameter int unsigned WIDTH  = 100,
    parameter int unsigned STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];
    logic [STAGES-1:0] rdy;

    // Word offered to stage 0 this cycle
    logic              src_v;
    logic [WIDTH-1:0]  src_d;

    // Stage k can load unless it and every stage after it are full while the consumer stalls
    always_comb begin
        logic full_tail;
        rdy = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            full_tail = 1'b1;
            for (int j = k; j < int'(STAGES); j++) begin
                full_tail = full_tail & v[j];
            end
            rdy[k] = ~full_tail | out_ready;
        end
    end

`ifdef STALL_PIPELINE_SKID_EN
    logic             skid_v;
    logic             skid_v_nxt;
    logic [WIDTH-1:0] skid_d;
    logic             in_ready_q;
    logic             accept;

    // Skid has priority into stage 0; a word accepted while stage 0 is blocked parks in skid
    always_comb begin
        accept     = in_valid & in_ready_q;
        src_v      = skid_v | accept;
        src_d      = skid_v ? skid_d : in_data;
        skid_v_nxt = skid_v ? ~rdy[0] : (accept & ~rdy[0]);
    end

    // Skid register and registered in_ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_v     <= 1'b0;
            skid_d     <= '0;
            in_ready_q <= 1'b0;
        end else if (flush) begin
            skid_v     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            skid_v     <= skid_v_nxt;
            in_ready_q <= ~skid_v_nxt;
            if (!skid_v && accept && !rdy[0]) begin
                skid_d <= in_data;
            end
        end
    end

    assign in_ready = in_ready_q;
`else
    // Without skid, stage 0 takes the upstream word directly
    always_comb begin
        src_v = in_valid;
        src_d = in_data;
    end

    assign in_ready = rdy[0];
`endif

    // Stage registers: shift when ready, data loads only with a valid word so bubbles keep old data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                d[k] <= '0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (rdy[0]) begin
                v[0] <= src_v;
                if (src_v) begin
                    d[0] <= src_d;
                end
            end
            for (int k = 1; k < int'(STAGES); k++) begin
                if (rdy[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        d[k] <= d[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = v[LAST];
    assign out_data  = d[LAST];

endmodule

// File: tb/tb_stall_pipeline.sv
// tb_stall_pipeline: directed vector table plus hand sequences for stall_pipeline (WIDTH=100, STAGES=3).
module tb_stall_pipeline;

    localparam int unsigned W = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int checks = 0;
    int errors = 0;

    stall_pipeline #(.WIDTH(W), .STAGES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic         flush;
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         chk_rdy;
        logic         exp_rdy;
        logic         exp_ov;
        logic         chk_d;
        logic [W-1:0] exp_d;
    } vec_t;

    localparam int NV = 21;
    vec_t tab [NV];

    function automatic vec_t mk(input logic r, input logic f, input logic iv, input int id,
                                input logic ordy, input logic cr, input logic er,
                                input logic ov, input logic cd, input int ed);
        vec_t t;
        t.rst_n = r;  t.flush = f;  t.iv = iv;  t.id = W'(id);  t.ordy = ordy;
        t.chk_rdy = cr;  t.exp_rdy = er;  t.exp_ov = ov;  t.chk_d = cd;  t.exp_d = W'(ed);
        return t;
    endfunction

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, got, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs and let combinational outputs settle before the edge
    task automatic drive(input logic r, input logic f, input logic iv, input int id, input logic ordy);
        rst_n     = r;
        flush     = f;
        in_valid  = iv;
        in_data   = W'(id);
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check registered outputs after an edge
    task automatic chk_out(input string name, input logic ov, input int dat, input logic cd);
        chk1({name, " out_valid"}, out_valid, ov);
        if (cd) chkd({name, " out_data"}, out_data, W'(dat));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset with a word offered, then idle, streaming 1..4, full stall 10..13 and release
        tab[0]  = mk(0,0,1,5, 1, 0,1, 0,1,0);
        tab[1]  = mk(0,0,1,5, 1, 1,1, 0,1,0);
        tab[2]  = mk(1,0,0,0, 1, 1,1, 0,1,0);
        tab[3]  = mk(1,0,0,0, 1, 1,1, 0,1,0);
        tab[4]  = mk(1,0,0,0, 1, 1,1, 0,1,0);
        tab[5]  = mk(1,0,1,1, 1, 1,1, 0,1,0);
        tab[6]  = mk(1,0,1,2, 1, 1,1, 0,1,0);
        tab[7]  = mk(1,0,1,3, 1, 1,1, 1,1,1);
        tab[8]  = mk(1,0,1,4, 1, 1,1, 1,1,2);
        tab[9]  = mk(1,0,0,0, 1, 1,1, 1,1,3);
        tab[10] = mk(1,0,0,0, 1, 1,1, 1,1,4);
        tab[11] = mk(1,0,0,0, 1, 1,1, 0,1,4);
        tab[12] = mk(1,0,1,10,0, 1,1, 0,1,4);
        tab[13] = mk(1,0,1,11,0, 1,1, 0,1,4);
        tab[14] = mk(1,0,1,12,0, 1,1, 1,1,10);
        tab[15] = mk(1,0,1,13,0, 1,0, 1,1,10);
        tab[16] = mk(1,0,1,13,0, 1,0, 1,1,10);
        tab[17] = mk(1,0,1,13,1, 1,1, 1,1,11);
        tab[18] = mk(1,0,0,0, 1, 1,1, 1,1,12);
        tab[19] = mk(1,0,0,0, 1, 1,1, 1,1,13);
        tab[20] = mk(1,0,0,0, 1, 1,1, 0,1,13);

        for (int i = 0; i < NV; i++) begin
            drive(tab[i].rst_n, tab[i].flush, tab[i].iv, int'(tab[i].id[31:0]), tab[i].ordy);
            if (tab[i].chk_rdy) chk1($sformatf("tab%0d in_ready", i), in_ready, tab[i].exp_rdy);
            tick();
            chk1($sformatf("tab%0d out_valid", i), out_valid, tab[i].exp_ov);
            if (tab[i].chk_d) chkd($sformatf("tab%0d out_data", i), out_data, tab[i].exp_d);
        end

        // Bubble collapse: A, two idle cycles, B, all while the consumer stalls
        drive(1,0,1,'hA,0); tick();
        drive(1,0,0,0,0);   tick();
        drive(1,0,0,0,0);   tick();
        chk_out("bub A at out", 1, 'hA, 1);
        drive(1,0,1,'hB,0);
        chk1("bub B in_ready", in_ready, 1);
        tick();
        drive(1,0,0,0,0);   tick();
        chk_out("bub stalled", 1, 'hA, 1);
        drive(1,0,0,0,1);   tick();
        chk_out("bub B adjacent", 1, 'hB, 1);
        tick();
        chk_out("bub empty", 0, 'hB, 1);

        // Full-pipe pass-through: fill 30..32, then 5 cycles of simultaneous accept and emit
        drive(1,0,1,30,0); tick();
        drive(1,0,1,31,0); tick();
        drive(1,0,1,32,0); tick();
        drive(1,0,1,33,0);
        chk1("pt full in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1,0,1,33+i,1);
            chk1($sformatf("pt%0d in_ready", i), in_ready, 1);
            chkd($sformatf("pt%0d emitted", i), out_data, W'(30+i));
            tick();
            chk_out($sformatf("pt%0d", i), 1, 31+i, 1);
        end
        drive(1,0,1,99,0);
        chk1("pt still full", in_ready, 0);
        tick();
        chk_out("pt hold", 1, 35, 1);
        drive(1,0,0,0,1); tick();
        chk_out("pt drain0", 1, 36, 1);
        tick();
        chk_out("pt drain1", 1, 37, 1);
        tick();
        chk_out("pt drain2", 0, 37, 1);

        // Flush with a simultaneous handshake on word 20
        drive(1,0,1,7,0); tick();
        drive(1,0,1,8,0); tick();
        drive(1,0,1,9,0); tick();
        chk_out("fl full", 1, 7, 1);
        drive(1,1,1,20,1); tick();
        chk_out("fl cleared", 0, 7, 1);
        drive(1,0,0,0,1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("fl idle%0d", i), 0, 0, 0);
        end

        // Reset mid-stream discards in-flight words and clears data
        drive(1,0,1,50,0); tick();
        drive(1,0,1,51,0); tick();
        drive(0,0,1,52,1); tick();
        chk_out("mid rst", 0, 0, 1);
        drive(1,0,0,0,1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("mid rst idle%0d", i), 0, 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
